bfp_width_tracker: RTL and testbench



---
 rtl/bfp_width_tracker.sv | 112 +++++++++++
 tb/tb_bfp_width_tracker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_width_tracker.sv
// Block-floating-point exponent detector: finds the widest sample in each FFT frame,
// publishes it with the matching shifter left-shift, and accumulates the block exponent.
module bfp_width_tracker #(
    parameter int FFT_DW            = 16,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int EXP_W             = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         s_valid,
    input  logic                         s_last,
    input  logic [FFT_DW-1:0]            s_re,
    input  logic [FFT_DW-1:0]            s_im,
    output logic [FFT_MAX_BIT_WIDTH-1:0] width_out,
    output logic                         width_valid,
    output logic [FFT_MAX_BIT_WIDTH-1:0] shift_out,
    output logic [EXP_W-1:0]             block_exp
);

    localparam int MW = FFT_MAX_BIT_WIDTH;

    // Significant width of a two's complement value; the most negative value needs every bit.
    function automatic logic [MW-1:0] comp_width(input logic [FFT_DW-1:0] x);
        logic [FFT_DW-1:0] y;
        logic [MW-1:0]     w;
        y = x[FFT_DW-1] ? ~x : x;
        w = '0;
        for (int i = 0; i < FFT_DW; i++) begin
            if (y[i]) begin
                w = MW'(i + 1);
            end
        end
        if (x == {1'b1, {(FFT_DW-1){1'b0}}}) begin
            w = MW'(FFT_DW);
        end
        return w;
    endfunction

    function automatic logic [MW-1:0] shift_for(input logic [MW-1:0] m);
        logic [MW-1:0] s;
        if (m == '0 || m == MW'(FFT_DW - 1) || m == MW'(FFT_DW)) begin
            s = '0;
        end else begin
            s = MW'(FFT_DW - 1) - m;
        end
        return s;
    endfunction

    logic [MW-1:0]    w_re, w_im, s_width;
    logic             s1_valid, s1_last;
    logic [MW-1:0]    s1_width;
    logic [MW-1:0]    run_max, frame_max;
    logic [EXP_W:0]   exp_sum;
    logic [EXP_W-1:0] exp_sat;

    always_comb begin
        w_re      = comp_width(s_re);
        w_im      = comp_width(s_im);
        s_width   = (w_re > w_im) ? w_re : w_im;
        frame_max = (s1_width > run_max) ? s1_width : run_max;
        exp_sum   = {1'b0, block_exp} + (EXP_W + 1)'(shift_out);
        exp_sat   = exp_sum[EXP_W] ? '1 : exp_sum[EXP_W-1:0];
    end

    // Stage 1: register the per-sample width; a beat arriving with clear is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_width <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= s_valid;
            s1_last  <= s_valid & s_last;
            s1_width <= s_width;
        end
    end

    // Stage 2: running max restarts from zero after each last beat, so back-to-back
    // frames never mix widths and a one-beat frame reports its own width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max     <= '0;
            width_out   <= '0;
            shift_out   <= '0;
            width_valid <= 1'b0;
            block_exp   <= '0;
        end else if (clear) begin
            run_max     <= '0;
            width_valid <= 1'b0;
            block_exp   <= '0;
        end else begin
            width_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    width_out <= frame_max;
                    shift_out <= shift_for(frame_max);
                    run_max   <= '0;
                end else begin
                    run_max <= frame_max;
                end
            end
            if (width_valid) begin
                block_exp <= exp_sat;
            end
        end
    end

endmodule

// File: tb/tb_bfp_width_tracker.sv
// Bench for bfp_width_tracker: directed frames plus random traffic against an
// event-level reference model; a second instance with a 4-bit exponent checks saturation.
module tb_bfp_width_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        s_valid;
    logic        s_last;
    logic [15:0] s_re;
    logic [15:0] s_im;

    logic [4:0]  width_out, shift_out;
    logic        width_valid;
    logic [7:0]  block_exp;

    logic [4:0]  width_out_s, shift_out_s;
    logic        width_valid_s;
    logic [3:0]  block_exp_s;

    int tests = 0;
    int fails = 0;

    // Reference model state: values expected after the most recent clock edge.
    int m_width, m_shift, m_be, m_be4, m_frame_max, m_pend_m;
    bit m_valid, m_pend;

    bfp_width_tracker dut (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_last(s_last),
        .s_re(s_re), .s_im(s_im), .width_out(width_out), .width_valid(width_valid),
        .shift_out(shift_out), .block_exp(block_exp)
    );

    bfp_width_tracker #(.EXP_W(4)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_last(s_last),
        .s_re(s_re), .s_im(s_im), .width_out(width_out_s), .width_valid(width_valid_s),
        .shift_out(shift_out_s), .block_exp(block_exp_s)
    );

    always #5 clk = ~clk;

    function automatic int bitWidth(input logic [15:0] x);
        int v;
        int n;
        v = int'($signed(x));
        if (v == -32768) return 16;
        if (v < 0) v = -v - 1;
        n = 0;
        while (v > 0) begin
            n++;
            v = v / 2;
        end
        return n;
    endfunction

    function automatic int shiftFor(input int m);
        return (m == 0 || m == 15 || m == 16) ? 0 : 15 - m;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkValue("width_valid", 32'(width_valid), 32'(m_valid));
        checkValue("width_out", 32'(width_out), 32'(m_width));
        checkValue("shift_out", 32'(shift_out), 32'(m_shift));
        checkValue("block_exp", 32'(block_exp), 32'(m_be));
        checkValue("block_exp_sat", 32'(block_exp_s), 32'(m_be4));
    endtask

    task automatic modelReset();
        m_width = 0; m_shift = 0; m_be = 0; m_be4 = 0;
        m_frame_max = 0; m_pend_m = 0; m_valid = 0; m_pend = 0;
    endtask

    // Advance the model across the next rising edge using the inputs now driven.
    task automatic modelEdge();
        bit prev_pulse;
        int prev_shift;
        int w;
        prev_pulse = m_valid;
        prev_shift = m_shift;
        if (clear) begin
            m_valid = 0; m_be = 0; m_be4 = 0; m_frame_max = 0; m_pend = 0;
        end else begin
            m_valid = m_pend;
            if (m_pend) begin
                m_width = m_pend_m;
                m_shift = shiftFor(m_pend_m);
                m_pend  = 0;
            end
            if (prev_pulse) begin
                m_be  = (m_be + prev_shift > 255) ? 255 : m_be + prev_shift;
                m_be4 = (m_be4 + prev_shift > 15) ? 15 : m_be4 + prev_shift;
            end
            if (s_valid) begin
                w = bitWidth(s_re);
                if (bitWidth(s_im) > w) w = bitWidth(s_im);
                if (w > m_frame_max) m_frame_max = w;
                if (s_last) begin
                    m_pend = 1;
                    m_pend_m = m_frame_max;
                    m_frame_max = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input bit l, input logic [15:0] re,
                                 input logic [15:0] im, input bit clr);
        @(negedge clk);
        checkOutput();
        s_valid = v;
        s_last  = l;
        s_re    = re;
        s_im    = im;
        clear   = clr;
        modelEdge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic asyncReset();
        @(negedge clk);
        checkOutput();
        s_valid = 0; s_last = 0; s_re = 0; s_im = 0; clear = 0;
        #2 rst = 1'b1;
        #1;
        checkValue("rst_width_out", 32'(width_out), 32'd0);
        checkValue("rst_shift_out", 32'(shift_out), 32'd0);
        checkValue("rst_block_exp", 32'(block_exp), 32'd0);
        checkValue("rst_width_valid", 32'(width_valid), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        modelEdge();
    endtask

    initial begin
        logic [15:0] rv, iv;
        rst = 1'b1; clear = 0; s_valid = 0; s_last = 0; s_re = 0; s_im = 0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        modelEdge();

        // Four-beat frame: widest beat 0x0100 gives width 9, shift 6.
        applyStimulus(1, 0, 16'h0003, 16'h0, 0);
        applyStimulus(1, 0, 16'h0100, 16'h0, 0);
        applyStimulus(1, 0, 16'h0010, 16'h0, 0);
        applyStimulus(1, 1, 16'h0001, 16'h0, 0);
        idle(3);
        checkValue("frame4_width", 32'(width_out), 32'd9);
        checkValue("frame4_shift", 32'(shift_out), 32'd6);
        checkValue("frame4_exp", 32'(block_exp), 32'd6);

        // Extremes as one-beat frames.
        applyStimulus(1, 1, 16'h8000, 16'h0, 0);
        idle(3);
        checkValue("min_width", 32'(width_out), 32'd16);
        checkValue("min_shift", 32'(shift_out), 32'd0);
        applyStimulus(1, 1, 16'h4000, 16'h0, 0);
        idle(3);
        checkValue("w15_width", 32'(width_out), 32'd15);
        checkValue("w15_shift", 32'(shift_out), 32'd0);
        applyStimulus(1, 1, 16'h0000, 16'h0, 0);
        idle(3);
        checkValue("zero_width", 32'(width_out), 32'd0);
        applyStimulus(1, 1, 16'h0000, 16'hFFFE, 0);
        idle(3);
        checkValue("neg2_width", 32'(width_out), 32'd1);
        checkValue("neg2_shift", 32'(shift_out), 32'd14);

        // Back-to-back frames with no idle cycle between them.
        applyStimulus(0, 0, 16'h0, 16'h0, 1);
        applyStimulus(1, 0, 16'h0FFF, 16'h0, 0);
        applyStimulus(1, 1, 16'h0010, 16'h0, 0);
        applyStimulus(1, 1, 16'h0007, 16'h0, 0);
        idle(4);
        checkValue("b2b_width", 32'(width_out), 32'd3);
        checkValue("b2b_exp", 32'(block_exp), 32'd15);

        // Saturation of the 4-bit exponent.
        applyStimulus(0, 0, 16'h0, 16'h0, 1);
        applyStimulus(1, 1, 16'h0, 16'hFFFE, 0);
        idle(3);
        checkValue("sat_exp1", 32'(block_exp_s), 32'd14);
        applyStimulus(1, 1, 16'h0, 16'hFFFE, 0);
        idle(3);
        checkValue("sat_exp2", 32'(block_exp_s), 32'd15);
        applyStimulus(1, 1, 16'h0, 16'hFFFE, 0);
        idle(3);
        checkValue("sat_exp3", 32'(block_exp_s), 32'd15);
        checkValue("wide_exp3", 32'(block_exp), 32'd42);

        // Asynchronous reset mid-frame discards the width-10 beats.
        applyStimulus(1, 0, 16'h0200, 16'h0, 0);
        applyStimulus(1, 0, 16'h0300, 16'h0, 0);
        asyncReset();
        applyStimulus(1, 1, 16'h0008, 16'h0, 0);
        idle(3);
        checkValue("after_rst_width", 32'(width_out), 32'd4);

        // Clear mid-frame, then a clear colliding with a last beat.
        applyStimulus(1, 0, 16'h1000, 16'h0, 0);
        applyStimulus(1, 0, 16'h1FFF, 16'h0, 0);
        applyStimulus(0, 0, 16'h0, 16'h0, 1);
        applyStimulus(1, 0, 16'h0010, 16'h0, 0);
        applyStimulus(1, 1, 16'h001F, 16'h0, 0);
        idle(3);
        checkValue("clear_width", 32'(width_out), 32'd5);
        checkValue("clear_exp", 32'(block_exp), 32'd10);
        applyStimulus(1, 1, 16'h7FFF, 16'h0, 1);
        idle(3);
        checkValue("clear_last_width", 32'(width_out), 32'd5);
        checkValue("clear_last_exp", 32'(block_exp), 32'd0);

        // Random traffic: gaps, varied magnitudes, occasional clears.
        for (int i = 0; i < 400; i++) begin
            rv = 16'($signed(16'($urandom)) >>> $urandom_range(0, 15));
            iv = 16'($signed(16'($urandom)) >>> $urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) rv = 16'h8000;
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, rv, iv,
                          $urandom_range(0, 39) == 0);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
